// File: rtl/fc_pkg.sv
// Shared constants and state type for the fully-connected layer input loaders.
package fc_pkg;

    localparam int FC1_IN    = 400;
    localparam int ACT_WIDTH = 8;

    typedef enum logic [1:0] {
        FILL,
        SETTLE,
        VALID
    } loader_state_t;

endpackage

// File: rtl/fc_input_loader.sv
// Assembles a streamed activation frame into a stable IN-entry vector for the FC layer,
// waits SETTLE cycles for the combinational tree, then presents it with valid/ready.
module fc_input_loader
    import fc_pkg::*;
#(
    parameter int WIDTH  = ACT_WIDTH,
    parameter int IN     = FC1_IN,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] x [0:IN-1],
    output logic             x_valid,
    input  logic             x_ready,
    output logic             frame_err
);

    localparam int CW = (IN > 1) ? $clog2(IN) : 1;
    localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [CW-1:0] LAST_IDX    = CW'(IN - 1);
    localparam logic [SW-1:0] SETTLE_LOAD = (SETTLE > 0) ? SW'(SETTLE - 1) : '0;

    loader_state_t    state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic             x_valid_q, x_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             x_we;
    logic             accept;
    logic [WIDTH-1:0] x_q [0:IN-1];

    assign in_ready  = (state_q == FILL) && !rst;
    assign accept    = in_valid && in_ready;
    assign x_valid   = x_valid_q;
    assign frame_err = frame_err_q;
    assign x         = x_q;

    // The SETTLE parameter shadows the imported state name, so the state is package-qualified.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        settle_d    = settle_q;
        frame_err_d = 1'b0;
        x_we        = 1'b0;
        case (state_q)
            FILL: begin
                if (accept) begin
                    x_we = 1'b1;
                    if (count_q == LAST_IDX) begin
                        count_d = '0;
                        if (!in_last) begin
                            frame_err_d = 1'b1;
                        end else if (SETTLE == 0) begin
                            state_d = VALID;
                        end else begin
                            state_d  = fc_pkg::SETTLE;
                            settle_d = SETTLE_LOAD;
                        end
                    end else if (in_last) begin
                        count_d     = '0;
                        frame_err_d = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            fc_pkg::SETTLE: begin
                if (settle_q == '0) begin
                    state_d = VALID;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            VALID: begin
                if (x_ready) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
        x_valid_d = (state_d == VALID);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            count_q     <= '0;
            settle_q    <= '0;
            x_valid_q   <= 1'b0;
            frame_err_q <= 1'b0;
            for (int unsigned i = 0; i < IN; i++) begin
                x_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            settle_q    <= settle_d;
            x_valid_q   <= x_valid_d;
            frame_err_q <= frame_err_d;
            if (x_we) begin
                x_q[count_q] <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_fc_input_loader.sv
// Randomized self-checking bench for fc_input_loader (SETTLE=2 and SETTLE=0 builds).
module tb_fc_input_loader;

    localparam int N  = 400;
    localparam int ST = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic [7:0] x [0:N-1];
    logic       x_valid;
    logic       x_ready = 1'b1;
    logic       frame_err;

    logic [7:0] in_data0 = '0;
    logic       in_valid0 = 1'b0;
    logic       in_last0 = 1'b0;
    logic       in_ready0;
    logic [7:0] x0 [0:N-1];
    logic       x_valid0;
    logic       x_ready0 = 1'b0;
    logic       frame_err0;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] model_x [N];
    logic [7:0] model_x0 [N];
    logic [7:0] frame [N];

    fc_input_loader #(.WIDTH(8), .IN(N), .SETTLE(ST)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .x(x), .x_valid(x_valid), .x_ready(x_ready), .frame_err(frame_err)
    );

    fc_input_loader #(.WIDTH(8), .IN(N), .SETTLE(0)) dut0 (
        .clk(clk), .rst(rst), .in_data(in_data0), .in_valid(in_valid0), .in_last(in_last0),
        .in_ready(in_ready0), .x(x0), .x_valid(x_valid0), .x_ready(x_ready0), .frame_err(frame_err0)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int first_diff(input bit sel);
        for (int i = 0; i < N; i++) begin
            if (!sel && x[i] !== model_x[i]) return i;
            if (sel && x0[i] !== model_x0[i]) return i;
        end
        return -1;
    endfunction

    task automatic random_frame();
        for (int i = 0; i < N; i++) frame[i] = 8'($urandom);
    endtask

    // Streams frame[0..n-1] into the SETTLE=2 loader; whatever gets written lands at index k.
    task automatic stream(input int n, input int last_at);
        for (int k = 0; k < n; k++) begin
            int w;
            in_valid = 1'b1;
            in_data  = frame[k];
            in_last  = (k == last_at);
            w = 0;
            while (!in_ready && w < 50) begin
                tick();
                w++;
            end
            if (!in_ready) begin
                vectors++;
                miscompares++;
                $display("FAIL stream_ready_timeout elem=%0d in_ready=%b required 1", k, in_ready);
            end
            tick();
            model_x[k] = frame[k];
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        for (int i = 0; i < N; i++) begin
            model_x[i]  = '0;
            model_x0[i] = '0;
        end
        vectors++;
        if (in_ready !== 1'b0 || in_ready0 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_in_ready got %b/%b required 0/0", in_ready, in_ready0);
        end
        vectors++;
        if (x_valid !== 1'b0 || frame_err !== 1'b0 || x_valid0 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags x_valid=%b frame_err=%b x_valid0=%b required 0", x_valid, frame_err, x_valid0);
        end
        vectors++;
        if (first_diff(0) != -1 || first_diff(1) != -1) begin
            miscompares++;
            $display("FAIL reset_x idx=%0d/%0d required all zero", first_diff(0), first_diff(1));
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_in_ready got %b required 1", in_ready);
        end
    endtask

    task automatic check_latency(input string name);
        for (int c = 0; c < ST; c++) begin
            vectors++;
            if (x_valid !== 1'b0 || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL %s_settle c=%0d x_valid=%b in_ready=%b required 0/0", name, c, x_valid, in_ready);
            end
            tick();
        end
        vectors++;
        if (x_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_x_valid got %b required 1", name, x_valid);
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < N; i++) frame[i] = 8'(i);
        stream(N, N - 1);
        check_latency("basic");
        vectors++;
        if (x[0] !== 8'h00 || x[255] !== 8'hFF || x[399] !== 8'h8F) begin
            miscompares++;
            $display("FAIL basic_points x0=%h x255=%h x399=%h required 00/ff/8f", x[0], x[255], x[399]);
        end
        vectors++;
        if (first_diff(0) != -1) begin
            miscompares++;
            $display("FAIL basic_vector idx=%0d got %h", first_diff(0), x[first_diff(0)]);
        end
        tick();
        vectors++;
        if (x_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_handshake x_valid=%b in_ready=%b required 0/1", x_valid, in_ready);
        end
    endtask

    task automatic test_hold();
        random_frame();
        x_ready = 1'b0;
        stream(N, N - 1);
        check_latency("hold");
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            #1;
            vectors++;
            if (x_valid !== 1'b1 || in_ready !== 1'b0 || first_diff(0) != -1) begin
                miscompares++;
                $display("FAIL hold_c%0d x_valid=%b in_ready=%b diff=%0d required 1/0/-1", c, x_valid, in_ready, first_diff(0));
            end
            tick();
        end
        in_valid = 1'b0;
        x_ready  = 1'b1;
        tick();
        vectors++;
        if (x_valid !== 1'b0 || in_ready !== 1'b1 || first_diff(0) != -1) begin
            miscompares++;
            $display("FAIL hold_release x_valid=%b in_ready=%b diff=%0d required 0/1/-1", x_valid, in_ready, first_diff(0));
        end
    endtask

    task automatic test_short_frame();
        random_frame();
        stream(101, 100);
        vectors++;
        if (frame_err !== 1'b1) begin
            miscompares++;
            $display("FAIL short_err_pulse got %b required 1", frame_err);
        end
        tick();
        vectors++;
        if (frame_err !== 1'b0 || x_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL short_err_end frame_err=%b x_valid=%b required 0/0", frame_err, x_valid);
        end
        for (int i = 0; i < N; i++) frame[i] = 8'hA5;
        stream(N, N - 1);
        check_latency("a5");
        vectors++;
        if (first_diff(0) != -1 || frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL a5_vector idx=%0d frame_err=%b required -1/0", first_diff(0), frame_err);
        end
        tick();
    endtask

    task automatic test_long_frame();
        random_frame();
        stream(N, -1);
        vectors++;
        if (frame_err !== 1'b1) begin
            miscompares++;
            $display("FAIL long_err_pulse got %b required 1", frame_err);
        end
        for (int c = 0; c < ST + 3; c++) begin
            vectors++;
            if (x_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL long_no_valid c=%0d got %b required 0", c, x_valid);
            end
            tick();
        end
        random_frame();
        stream(N, N - 1);
        check_latency("after_long");
        vectors++;
        if (first_diff(0) != -1) begin
            miscompares++;
            $display("FAIL after_long_vector idx=%0d", first_diff(0));
        end
        tick();
    endtask

    task automatic test_mid_reset();
        random_frame();
        stream(200, -1);
        rst = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_in_ready got %b required 0", in_ready);
        end
        tick();
        rst = 1'b0;
        #1;
        for (int i = 0; i < N; i++) model_x[i] = '0;
        vectors++;
        if (x_valid !== 1'b0 || in_ready !== 1'b1 || first_diff(0) != -1) begin
            miscompares++;
            $display("FAIL rst_fill x_valid=%b in_ready=%b diff=%0d required 0/1/-1", x_valid, in_ready, first_diff(0));
        end
        random_frame();
        stream(N, N - 1);
        vectors++;
        if (in_ready !== 1'b0 || x_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_in_settle in_ready=%b x_valid=%b required 0/0", in_ready, x_valid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        for (int i = 0; i < N; i++) model_x[i] = '0;
        vectors++;
        if (x_valid !== 1'b0 || in_ready !== 1'b1 || first_diff(0) != -1) begin
            miscompares++;
            $display("FAIL rst_settle x_valid=%b in_ready=%b diff=%0d required 0/1/-1", x_valid, in_ready, first_diff(0));
        end
        for (int c = 0; c < ST + 1; c++) begin
            vectors++;
            if (x_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_settle_idle c=%0d got %b required 0", c, x_valid);
            end
            tick();
        end
        random_frame();
        stream(N, N - 1);
        check_latency("post_rst");
        vectors++;
        if (first_diff(0) != -1) begin
            miscompares++;
            $display("FAIL post_rst_vector idx=%0d", first_diff(0));
        end
        tick();
    endtask

    task automatic test_settle0_gaps();
        random_frame();
        for (int k = 0; k < N; k++) begin
            in_valid0 = 1'b0;
            tick();
            tick();
            in_valid0 = 1'b1;
            in_data0  = frame[k];
            in_last0  = (k == N - 1);
            #1;
            if (!in_ready0 || (k == N - 1 && x_valid0 !== 1'b0)) begin
                vectors++;
                miscompares++;
                $display("FAIL s0_accept elem=%0d in_ready0=%b x_valid0=%b required 1/0", k, in_ready0, x_valid0);
            end
            tick();
            model_x0[k] = frame[k];
        end
        in_valid0 = 1'b0;
        in_last0  = 1'b0;
        vectors++;
        if (x_valid0 !== 1'b1 || frame_err0 !== 1'b0) begin
            miscompares++;
            $display("FAIL s0_latency x_valid0=%b frame_err0=%b required 1/0", x_valid0, frame_err0);
        end
        vectors++;
        if (first_diff(1) != -1) begin
            miscompares++;
            $display("FAIL s0_vector idx=%0d", first_diff(1));
        end
        x_ready0 = 1'b1;
        tick();
        x_ready0 = 1'b0;
        vectors++;
        if (x_valid0 !== 1'b0 || in_ready0 !== 1'b1) begin
            miscompares++;
            $display("FAIL s0_handshake x_valid0=%b in_ready0=%b required 0/1", x_valid0, in_ready0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_short_frame();
        test_long_frame();
        test_mid_reset();
        test_settle0_gaps();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fc_input_loader.md
Name: fc_input_loader

Overview:
- Upstream stage of each fully-connected layer neuron.
- Accepts the flattened pooled activation stream one element per handshake and assembles it into the IN-entry vector x[0:IN-1] that the combinational FC layer consumes.
- Holds the vector stable while the layer's multiplier/adder tree settles, then presents it with a valid/ready handshake.
- Checks frame length against in_last.

Parameters:
- WIDTH, 8, activation bit width; must match the FC layer's WIDTH.
- IN, 400, vector length (16 channels x 5 x 5 flattened).
- SETTLE, 2, cycles to wait after the last element before asserting x_valid; 0 allowed.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  streamed activation element.
- in_valid  input  1  in_data valid.
- in_last  input  1  marks final element of a frame; qualified by in_valid.
- in_ready  output  1  loader can accept an element.
- x  output  WIDTH x [0:IN-1]  assembled vector, unpacked array, drives FC layer x.
- x_valid  output  1  x is complete and settled.
- x_ready  input  1  consumer has sampled the FC result.
- frame_err  output  1  one-cycle pulse on framing error.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset state: state FILL, count 0, all x entries 0, x_valid 0, frame_err 0.
- in_ready is 0 in the cycle rst is high and 1 in FILL afterwards.
- count width is $clog2(IN) (9 bits for 400). The settle counter is $clog2(SETTLE+1) bits, minimum 1.
- An element is accepted when in_valid && in_ready.
- State FILL:
  - in_ready=1, x_valid=0.
  - On accept, x[count] <= in_data. First accepted element goes to x[0]; order is exactly arrival order.
  - Accept with count==IN-1 and in_last=1: count <= 0, go to SETTLE (or VALID directly if SETTLE==0).
  - Accept with count<IN-1 and in_last=1 (short frame): frame_err pulses next cycle, count <= 0, partial frame discarded, remain FILL. Already-written entries are not cleared; they are overwritten by the next frame.
  - Accept with count==IN-1 and in_last=0 (long frame): frame_err pulses, count <= 0, remain FILL, frame discarded.
- State SETTLE:
  - in_ready=0, x_valid=0. Settle counter loads SETTLE-1 on entry and decrements; at 0, go to VALID.
  - Occupancy: exactly SETTLE cycles.
- State VALID:
  - in_ready=0, x_valid=1.
  - When x_ready=1, the handshake completes that cycle; next cycle is FILL with x_valid=0.
  - x_ready high in the first VALID cycle completes the handshake immediately; x_ready while not VALID is ignored.
- x is register-driven and must not change outside FILL accepts. It is stable through SETTLE and VALID and remains after handshake until overwritten.
- Latency:
  - The last accept at cycle t gives x_valid high at t+1+SETTLE.
  - Minimum frame period is IN+SETTLE+1 cycles.
  - Single buffer: no overlap of fill and present.
- rst mid-operation from any state: return to reset state next cycle, partial frame lost, x cleared.
- in_data with in_valid=0 is ignored.
- No arithmetic is performed on data; widths pass through unchanged.

Decomposition:
- Shared package fc_pkg holds:
  - FC1_IN=400 and ACT_WIDTH=8 constants.
  - typedef enum logic [1:0] {FILL, SETTLE, VALID} loader_state_t, reused by later FC loaders.
- No sub-module: the block is one FSM, one element counter, one settle counter and the vector register file, kept flat.

Test Plan:
- Reset then stream 400 elements x[i]=i[7:0], in_last on the 400th, x_ready=1 (SETTLE=2) -> x_valid rises 3 cycles after the last accept; x[0]=0, x[255]=255, x[399]=143; x_valid drops next cycle; in_ready returns.
- Full frame with x_ready held 0 for 10 cycles -> x_valid stays 1, x stable, in_ready=0, and in_valid during that time is not accepted. x_ready=1 completes in 1 cycle.
- in_last on element 100 -> frame_err pulses once. The next 400-element frame with all in_data=8'hA5 yields x[0..399]=8'hA5 and a valid handshake.
- 400th element with in_last=0 -> frame_err pulses and x_valid never asserts. The following correct frame is accepted normally.
- rst asserted at element 200 and in SETTLE -> next cycle x_valid=0, all x=0, count restarts. A new frame loads from x[0].
- SETTLE=0 build: last accept at t -> x_valid=1 at t+1; in_valid with gaps (valid every 3rd cycle) still fills correctly.
